// File: rtl/id_ex_operand_buffer_if.sv
// Decode/execute/write-back signal bundle for the ID/EX operand buffer.
// master = decode + execute + write-back side, slave = the buffer itself.
interface id_ex_operand_buffer_if #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 12
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [REG_W-1:0]  IN_RS_A;
    logic [REG_W-1:0]  IN_RS_B;
    logic [DATA_W-1:0] IN_DATA_A;
    logic [DATA_W-1:0] IN_DATA_B;
    logic [REG_W-1:0]  IN_RD;
    logic [CTRL_W-1:0] IN_CTRL;
    logic [DATA_W-1:0] IN_IMM;
    logic              WB_WE;
    logic [REG_W-1:0]  WB_REG;
    logic [DATA_W-1:0] WB_DATA;
    logic              FLUSH;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [DATA_W-1:0] OUT_DATA_A;
    logic [DATA_W-1:0] OUT_DATA_B;
    logic [REG_W-1:0]  OUT_RD;
    logic [CTRL_W-1:0] OUT_CTRL;
    logic [DATA_W-1:0] OUT_IMM;

    modport master (
        output IN_VALID, IN_RS_A, IN_RS_B, IN_DATA_A, IN_DATA_B, IN_RD, IN_CTRL, IN_IMM,
        output WB_WE, WB_REG, WB_DATA, FLUSH, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA_A, OUT_DATA_B, OUT_RD, OUT_CTRL, OUT_IMM
    );

    modport slave (
        input  IN_VALID, IN_RS_A, IN_RS_B, IN_DATA_A, IN_DATA_B, IN_RD, IN_CTRL, IN_IMM,
        input  WB_WE, WB_REG, WB_DATA, FLUSH, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA_A, OUT_DATA_B, OUT_RD, OUT_CTRL, OUT_IMM
    );
endinterface

// File: rtl/id_ex_operand_buffer.sv
// Two-entry (head + skid) decode-to-execute operand buffer with write-back bypass
// at capture time and continuous write-back snooping of buffered operands.
module id_ex_operand_buffer #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 12
) (
    input logic                   CLK,
    input logic                   RST,
    id_ex_operand_buffer_if.slave bus
);
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_W-1:0]  rs_a;
        logic [REG_W-1:0]  rs_b;
        logic [REG_W-1:0]  rd;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] imm;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state, state_n;
    entry_t ent_p0, ent_p1, ent_p0_n, ent_p1_n, cap;
    logic   vld_p0, vld_p1, accept, pop;

    function automatic logic [DATA_W-1:0] snoop(
        input logic [DATA_W-1:0] cur,
        input logic [REG_W-1:0]  rs,
        input logic              we,
        input logic [REG_W-1:0]  wreg,
        input logic [DATA_W-1:0] wdata
    );
        return (we && (rs == wreg)) ? wdata : cur;
    endfunction

    assign vld_p0       = (state != EMPTY);
    assign vld_p1       = (state == FULL);
    assign bus.IN_READY = (state != FULL) & ~bus.FLUSH;
    assign accept       = bus.IN_VALID & bus.IN_READY;
    assign pop          = vld_p0 & bus.OUT_READY;

    // Capture stage: the register file writes at the edge, so a same-cycle write wins
    always_comb begin
        cap      = '0;
        cap.a    = snoop(bus.IN_DATA_A, bus.IN_RS_A, bus.WB_WE, bus.WB_REG, bus.WB_DATA);
        cap.b    = snoop(bus.IN_DATA_B, bus.IN_RS_B, bus.WB_WE, bus.WB_REG, bus.WB_DATA);
        cap.rs_a = bus.IN_RS_A;
        cap.rs_b = bus.IN_RS_B;
        cap.rd   = bus.IN_RD;
        cap.ctrl = bus.IN_CTRL;
        cap.imm  = bus.IN_IMM;
    end

    always_comb begin
        state_n = state;
        if (bus.FLUSH) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (accept) state_n = ONE;
                ONE: begin
                    if (accept && !pop)      state_n = FULL;
                    else if (pop && !accept) state_n = EMPTY;
                end
                FULL:    if (pop) state_n = ONE;
                default: state_n = EMPTY;
            endcase
        end
    end

    always_comb begin
        ent_p0_n = ent_p0;
        ent_p1_n = ent_p1;
        if (vld_p0) begin
            ent_p0_n.a = snoop(ent_p0.a, ent_p0.rs_a, bus.WB_WE, bus.WB_REG, bus.WB_DATA);
            ent_p0_n.b = snoop(ent_p0.b, ent_p0.rs_b, bus.WB_WE, bus.WB_REG, bus.WB_DATA);
        end
        if (vld_p1) begin
            ent_p1_n.a = snoop(ent_p1.a, ent_p1.rs_a, bus.WB_WE, bus.WB_REG, bus.WB_DATA);
            ent_p1_n.b = snoop(ent_p1.b, ent_p1.rs_b, bus.WB_WE, bus.WB_REG, bus.WB_DATA);
        end
        case (state)
            EMPTY: if (accept) ent_p0_n = cap;
            ONE: begin
                if (accept && pop) ent_p0_n = cap;
                else if (accept)   ent_p1_n = cap;
            end
            // Skid entry carries this edge's snoop into the head
            FULL:    if (pop) ent_p0_n = ent_p1_n;
            default: ;
        endcase
    end

    // Head (p0) / skid (p1) registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= EMPTY;
            ent_p0 <= '0;
            ent_p1 <= '0;
        end else begin
            state  <= state_n;
            ent_p0 <= ent_p0_n;
            ent_p1 <= ent_p1_n;
        end
    end

    assign bus.OUT_VALID  = vld_p0;
    assign bus.OUT_DATA_A = ent_p0.a;
    assign bus.OUT_DATA_B = ent_p0.b;
    assign bus.OUT_RD     = ent_p0.rd;
    assign bus.OUT_CTRL   = ent_p0.ctrl;
    assign bus.OUT_IMM    = ent_p0.imm;
endmodule

// File: tb/tb_id_ex_operand_buffer.sv
// Scoreboard bench for id_ex_operand_buffer: directed scenarios plus randomized traffic
// checked against a queue-based model of a two-deep FIFO with write-back forwarding.
module tb_id_ex_operand_buffer;
    localparam int DATA_W = 64;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 12;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_W-1:0]  rs_a;
        logic [REG_W-1:0]  rs_b;
        logic [REG_W-1:0]  rd;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] imm;
    } ent_t;

    logic CLK;
    logic RST;
    int   n_chk;
    int   n_err;
    ent_t q[$];
    logic zero_hold;

    id_ex_operand_buffer_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) bus ();

    id_ex_operand_buffer #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Model: scoreboard updated mid-cycle for the coming edge (inputs are stable until after it)
    logic exp_valid, exp_ready, m_acc, m_pop;
    ent_t m_new;
    always @(negedge CLK) begin
        if (!RST) begin
            exp_valid = (q.size() != 0);
            exp_ready = (q.size() < 2) && !bus.FLUSH;
            chk("out_valid", bus.OUT_VALID, exp_valid);
            chk("in_ready", bus.IN_READY, exp_ready);
            if (exp_valid) begin
                chk("head_a", bus.OUT_DATA_A, q[0].a);
                chk("head_b", bus.OUT_DATA_B, q[0].b);
                chk("head_rd_ctrl_imm", {bus.OUT_RD, bus.OUT_CTRL, bus.OUT_IMM[DATA_W-REG_W-CTRL_W-1:0]},
                    {q[0].rd, q[0].ctrl, q[0].imm[DATA_W-REG_W-CTRL_W-1:0]});
            end else if (zero_hold) begin
                chk("idle_data_a_zero", bus.OUT_DATA_A, '0);
            end
            m_acc = bus.IN_VALID && exp_ready;
            m_pop = exp_valid && bus.OUT_READY;
            if (bus.WB_WE) begin
                foreach (q[i]) begin
                    if (q[i].rs_a == bus.WB_REG) q[i].a = bus.WB_DATA;
                    if (q[i].rs_b == bus.WB_REG) q[i].b = bus.WB_DATA;
                end
            end
            if (m_pop) void'(q.pop_front());
            if (bus.FLUSH) q.delete();
            if (m_acc) begin
                m_new.rs_a = bus.IN_RS_A;
                m_new.rs_b = bus.IN_RS_B;
                m_new.a    = (bus.WB_WE && bus.WB_REG == bus.IN_RS_A) ? bus.WB_DATA : bus.IN_DATA_A;
                m_new.b    = (bus.WB_WE && bus.WB_REG == bus.IN_RS_B) ? bus.WB_DATA : bus.IN_DATA_B;
                m_new.rd   = bus.IN_RD;
                m_new.ctrl = bus.IN_CTRL;
                m_new.imm  = bus.IN_IMM;
                q.push_back(m_new);
                zero_hold = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [REG_W-1:0] rsa, input logic [REG_W-1:0] rsb,
                        input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] da,
                        input logic [DATA_W-1:0] db);
        bus.IN_VALID  = 1'b1;
        bus.IN_RS_A   = rsa;
        bus.IN_RS_B   = rsb;
        bus.IN_RD     = rd;
        bus.IN_DATA_A = da;
        bus.IN_DATA_B = db;
        bus.IN_CTRL   = CTRL_W'($urandom());
        bus.IN_IMM    = rnd64();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        zero_hold = 1'b1;
        RST = 1'b1;
        bus.IN_VALID = 1'b0; bus.IN_RS_A = '0; bus.IN_RS_B = '0; bus.IN_RD = '0;
        bus.IN_DATA_A = '0; bus.IN_DATA_B = '0; bus.IN_CTRL = '0; bus.IN_IMM = '0;
        bus.WB_WE = 1'b0; bus.WB_REG = '0; bus.WB_DATA = '0; bus.FLUSH = 1'b0; bus.OUT_READY = 1'b0;
        cyc(); cyc();
        RST = 1'b0;

        // Reset then idle
        for (int i = 0; i < 5; i++) begin
            cyc(); #2;
            chk("rst_out_valid", bus.OUT_VALID, '0);
            chk("rst_in_ready", bus.IN_READY, 1);
            chk("rst_data_a", bus.OUT_DATA_A, '0);
        end

        // Single pass-through
        cyc();
        bus.OUT_READY = 1'b1;
        send(5'd4, 5'd5, 5'd1, 64'hA, 64'h5);
        cyc();
        bus.IN_VALID = 1'b0;
        #2;
        chk("t2_valid", bus.OUT_VALID, 1);
        chk("t2_a", bus.OUT_DATA_A, 64'hA);
        chk("t2_b", bus.OUT_DATA_B, 64'h5);
        cyc(); #2;
        chk("t2_empty", bus.OUT_VALID, 0);

        // Same-cycle write-back bypass
        cyc();
        send(5'd10, 5'd3, 5'd2, 64'h0, 64'h77);
        bus.WB_WE = 1'b1; bus.WB_REG = 5'd10; bus.WB_DATA = 64'h1234;
        cyc();
        bus.IN_VALID = 1'b0; bus.WB_WE = 1'b0;
        #2;
        chk("t3_bypass_a", bus.OUT_DATA_A, 64'h1234);
        chk("t3_b", bus.OUT_DATA_B, 64'h77);
        cyc();

        // Fill, snoop held skid entry, drain in order
        bus.OUT_READY = 1'b0;
        send(5'd1, 5'd2, 5'd3, 64'h11, 64'h22);
        cyc();
        send(5'd6, 5'd11, 5'd7, 64'h66, 64'h1111);
        cyc();
        bus.IN_VALID = 1'b0;
        #2;
        chk("t4_full_not_ready", bus.IN_READY, 0);
        cyc();
        bus.WB_WE = 1'b1; bus.WB_REG = 5'd11; bus.WB_DATA = 64'hBEEF;
        cyc();
        bus.WB_WE = 1'b0; bus.OUT_READY = 1'b1;
        #2;
        chk("t4_first_rd", bus.OUT_RD, 5'd3);
        cyc(); #2;
        chk("t4_second_rd", bus.OUT_RD, 5'd7);
        chk("t4_second_b", bus.OUT_DATA_B, 64'hBEEF);
        cyc(); #2;
        chk("t4_drained", bus.OUT_VALID, 0);

        // FLUSH while FULL with an incoming instruction
        bus.OUT_READY = 1'b0;
        send(5'd8, 5'd9, 5'd12, rnd64(), rnd64());
        cyc();
        send(5'd13, 5'd14, 5'd15, rnd64(), rnd64());
        cyc();
        send(5'd16, 5'd17, 5'd18, rnd64(), rnd64());
        bus.FLUSH = 1'b1;
        #1;
        chk("t5_flush_ready", bus.IN_READY, 0);
        cyc();
        bus.FLUSH = 1'b0; bus.IN_VALID = 1'b0;
        #2;
        chk("t5_flushed_valid", bus.OUT_VALID, 0);
        chk("t5_flushed_ready", bus.IN_READY, 1);

        // Asynchronous reset between edges while FULL
        cyc();
        send(5'd19, 5'd20, 5'd21, rnd64(), rnd64());
        cyc();
        send(5'd22, 5'd23, 5'd24, rnd64(), rnd64());
        cyc();
        bus.IN_VALID = 1'b0;
        #1;
        RST = 1'b1;
        #1;
        chk("t6_async_rst_valid", bus.OUT_VALID, 0);
        chk("t6_async_rst_ready", bus.IN_READY, 1);
        q.delete();
        zero_hold = 1'b1;
        RST = 1'b0;
        cyc();
        bus.OUT_READY = 1'b1;
        send(5'd25, 5'd26, 5'd27, 64'hCAFE, rnd64());
        cyc();
        bus.IN_VALID = 1'b0;
        #2;
        chk("t6_alone_rd", bus.OUT_RD, 5'd27);
        chk("t6_alone_a", bus.OUT_DATA_A, 64'hCAFE);
        cyc(); #2;
        chk("t6_alone_empty", bus.OUT_VALID, 0);

        // Randomized traffic with frequent register-index collisions
        for (int i = 0; i < 600; i++) begin
            cyc();
            if ($urandom_range(9) < 7) send(REG_W'($urandom_range(7)), REG_W'($urandom_range(7)),
                                            REG_W'($urandom()), rnd64(), rnd64());
            else bus.IN_VALID = 1'b0;
            bus.OUT_READY = ($urandom_range(9) < 6);
            bus.WB_WE     = $urandom_range(1);
            bus.WB_REG    = (i % 50 == 7) ? 5'd31 : REG_W'($urandom_range(7));
            bus.WB_DATA   = rnd64();
            bus.FLUSH     = ($urandom_range(19) == 0);
        end

        cyc();
        bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1; bus.WB_WE = 1'b0; bus.FLUSH = 1'b0;
        cyc(); cyc(); cyc(); #2;
        chk("final_drain", bus.OUT_VALID, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
